// File: rtl/hist_stat_accum.sv
// hist_stat_accum: per-frame gray-level histogram with cumulative (CDF) readout.
// Counts one active frame, streams 256 CDF entries, waits for the mapper's ack, then clears.
module hist_stat_accum #(
  parameter logic [10:0] H_DISP = 11'd800,
  parameter logic [10:0] V_DISP = 11'd600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_img_vsync,
  input  logic        pre_img_hsync,
  input  logic        pre_img_valid,
  input  logic [7:0]  pre_img_gray,
  output logic [7:0]  pixel_level,
  output logic [20:0] pixel_cnt_num,
  output logic        pixel_level_vld,
  input  logic        pixel_write_ok,
  output logic        hist_busy,
  output logic        frame_drop
);
  localparam logic [20:0] NPIX = 21'(H_DISP) * 21'(V_DISP);
  typedef enum logic [2:0] {CLEAR, IDLE, STAT, ACCUM, WAIT_OK} state_t;
  state_t      state_q, state_d;
  logic        vs_r_q, vs_r1_q, vsync_neg, unused_hsync;
  logic [20:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]  drain_q, drain_d;
  logic [7:0]  clr_q, clr_d;
  logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [7:0]  s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [20:0] s2_data_q, s2_data_d, rd_q, rd_d;
  logic [8:0]  rd_addr_q, rd_addr_d;
  logic        rd_vld_q, rd_vld_d;
  logic [7:0]  rd_lvl_q, rd_lvl_d, level_q, level_d;
  logic [20:0] acc_q, acc_d, cnt_q, cnt_d;
  logic        vld_q, vld_d, drop_q, drop_d;
  logic        stat_full, accept, drain_last, fetch, we;
  logic [7:0]  ra, wa;
  logic [20:0] wd;
  logic [20:0] hist_q [256];
  assign unused_hsync = pre_img_hsync;
  assign vsync_neg    = !vs_r_q & vs_r1_q;
  assign hist_busy    = state_q inside {ACCUM, WAIT_OK, CLEAR};
  assign pixel_level     = level_q;
  assign pixel_cnt_num   = cnt_q;
  assign pixel_level_vld = vld_q;
  assign frame_drop      = drop_q;
  always_comb begin
    stat_full  = pix_cnt_q == NPIX;
    accept     = state_q == STAT && pre_img_valid && !stat_full;
    drain_last = state_q == STAT && stat_full && drain_q[0] && !vsync_neg;
    // level 0 is fetched in the last drain cycle; the read port's write-through sees the final pixel
    fetch      = drain_last || (state_q == ACCUM && !rd_addr_q[8]);
    ra         = (state_q == STAT && !stat_full) ? pre_img_gray : rd_addr_q[7:0];
    we         = state_q == CLEAR || s2_vld_q;
    wa         = state_q == CLEAR ? clr_q : s2_addr_q;
    wd         = state_q == CLEAR ? 21'd0 : s2_data_q;
    rd_d       = (we && wa == ra) ? wd : hist_q[ra];
    s1_vld_d   = accept;
    s1_addr_d  = pre_img_gray;
    s2_vld_d   = s1_vld_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = ((s2_vld_q && s2_addr_q == s1_addr_q) ? s2_data_q : rd_q) + 21'd1;
    drain_d    = (state_q == STAT && stat_full && !vsync_neg) ? drain_q + 2'd1 : 2'd0;
    rd_addr_d  = fetch ? rd_addr_q + 9'd1 : (state_q == ACCUM ? rd_addr_q : 9'd0);
    rd_vld_d   = fetch;
    rd_lvl_d   = rd_addr_q[7:0];
    acc_d      = rd_vld_q ? acc_q + rd_q : (state_q == ACCUM ? acc_q : 21'd0);
    vld_d      = rd_vld_q;
    level_d    = rd_vld_q ? rd_lvl_q : level_q;
    cnt_d      = rd_vld_q ? acc_q + rd_q : cnt_q;
    drop_d     = vsync_neg && hist_busy;
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    clr_d      = clr_q;
    case (state_q)
      CLEAR: begin
        clr_d = clr_q + 8'd1;
        if (clr_q == 8'd255) state_d = IDLE;
      end
      IDLE: if (vsync_neg) begin
        state_d   = STAT;
        pix_cnt_d = '0;
      end
      STAT: begin
        pix_cnt_d = vsync_neg ? 21'd0 : accept ? pix_cnt_q + 21'd1 : pix_cnt_q;
        if (drain_last) state_d = ACCUM;
      end
      ACCUM:   if (rd_addr_q[8] && !rd_vld_q) state_d = WAIT_OK;
      WAIT_OK: if (pixel_write_ok) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (we) hist_q[wa] <= wd;
    rd_q <= rd_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      vs_r_q    <= 1'b0;
      vs_r1_q   <= 1'b0;
      pix_cnt_q <= '0;
      drain_q   <= '0;
      clr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_lvl_q  <= '0;
      acc_q     <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_r_q    <= pre_img_vsync;
      vs_r1_q   <= vs_r_q;
      pix_cnt_q <= pix_cnt_d;
      drain_q   <= drain_d;
      clr_q     <= clr_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      s2_vld_q  <= s2_vld_d;
      s2_addr_q <= s2_addr_d;
      s2_data_q <= s2_data_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      rd_lvl_q  <= rd_lvl_d;
      acc_q     <= acc_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      drop_q    <= drop_d;
    end
  end
endmodule

// File: tb/tb_hist_stat_accum.sv
// tb_hist_stat_accum: random and directed frames on a 4x2 frame, CDF checked against a histogram model.
module tb_hist_stat_accum;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, vsync = 1, hsync = 0, valid = 0, ack = 0;
  logic [7:0]  gray = '0, pixel_level;
  logic [20:0] pixel_cnt_num;
  logic        pixel_level_vld, hist_busy, frame_drop;
  int errors = 0, checks = 0, cyc = 0;
  int hist_m [256];
  int cdf_exp [256];
  int exp_lvl = 0, burst_cnt = 0, bursts_done = 0, drop_cnt = 0;
  int first_vld_cyc = 0, last_pix_cyc = 0;
  bit prev_vld = 0;

  hist_stat_accum #(.H_DISP(11'd4), .V_DISP(11'd2)) dut (
    .clk(clk), .rst_n(rst_n), .pre_img_vsync(vsync), .pre_img_hsync(hsync),
    .pre_img_valid(valid), .pre_img_gray(gray), .pixel_level(pixel_level),
    .pixel_cnt_num(pixel_cnt_num), .pixel_level_vld(pixel_level_vld),
    .pixel_write_ok(ack), .hist_busy(hist_busy), .frame_drop(frame_drop));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare process: every CDF entry against the model, burst shape at the end
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 0; exp_lvl = 0; burst_cnt = 0;
    end else begin
      if (pixel_level_vld) begin
        if (!prev_vld) first_vld_cyc = cyc;
        chk("level_seq", pixel_level, exp_lvl);
        chk("cdf", pixel_cnt_num, cdf_exp[pixel_level]);
        exp_lvl++; burst_cnt++;
      end else if (prev_vld) begin
        chk("burst_len", burst_cnt, 256);
        chk("hold_level", pixel_level, 255);
        chk("hold_cnt", pixel_cnt_num, cdf_exp[255]);
        burst_cnt = 0; exp_lvl = 0; bursts_done++;
      end
      if (frame_drop) drop_cnt++;
      prev_vld = pixel_level_vld;
    end
  end

  task automatic send_frame(input int mode, input bit count);
    int g, acc;
    if (count) foreach (hist_m[k]) hist_m[k] = 0;
    @(negedge clk); vsync = 0;
    repeat (3) @(negedge clk);
    if (count) chk("busy_in_stat", hist_busy, 0);
    for (int i = 0; i < N; i++) begin
      valid = 0;
      if (mode >= 3) repeat ($urandom_range(0, 2)) @(negedge clk);
      g = mode == 0 ? i : mode == 1 ? 200 : mode == 2 ? 0 :
          mode == 3 ? int'($urandom_range(0, 255)) : mode == 4 ? int'($urandom_range(0, 3)) : 77;
      gray = 8'(g); valid = 1;
      if (count) begin
        hist_m[g]++;
        if (i == N - 1) last_pix_cyc = cyc + 1;
      end
      @(negedge clk);
    end
    if (count) begin
      acc = 0;
      for (int k = 0; k < 256; k++) begin acc += hist_m[k]; cdf_exp[k] = acc; end
    end
    repeat (2) begin gray = 8'($urandom); @(negedge clk); end
    valid = 0; vsync = 1;
  endtask

  task automatic wait_burst();
    int start = bursts_done;
    for (int i = 0; i < 2000 && bursts_done == start; i++) @(negedge clk);
    chk("burst_seen", bursts_done != start, 1);
    chk("latency_le4", (first_vld_cyc - last_pix_cyc) <= 4, 1);
  endtask

  task automatic wait_level(input int l);
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = pixel_level_vld && pixel_level == 8'(l);
    end
    chk("reach_level", found, 1);
  endtask

  task automatic clear_timing();
    repeat (255) @(negedge clk);
    chk("busy_during_clear", hist_busy, 1);
    @(negedge clk);
    chk("idle_after_clear", hist_busy, 0);
  endtask

  task automatic ack_clear(input int d);
    repeat (d) @(negedge clk);
    ack = 1; @(negedge clk); ack = 0;
    clear_timing();
  endtask

  task automatic chk_reset_vals();
    chk("rst_level", pixel_level, 0);
    chk("rst_cnt", pixel_cnt_num, 0);
    chk("rst_vld", pixel_level_vld, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_busy", hist_busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #15 chk_reset_vals();
    @(negedge clk); rst_n = 1;
    clear_timing();
    // ramp 0..7
    send_frame(0, 1);
    chk("model_pin_l0", cdf_exp[0], 1);
    chk("model_pin_l7", cdf_exp[7], 8);
    chk("model_pin_l255", cdf_exp[255], 8);
    wait_burst();
    chk("ramp_last_entry", pixel_cnt_num, 8);
    ack_clear(10);
    // all 200 back-to-back, ack pulsed mid-burst must be ignored
    send_frame(1, 1);
    chk("model_pin_l199", cdf_exp[199], 0);
    chk("model_pin_l200", cdf_exp[200], 8);
    wait_level(20);
    ack = 1; @(negedge clk); ack = 0;
    wait_burst();
    repeat (300) @(negedge clk);
    chk("ack_ignored_in_accum", hist_busy, 1);
    ack_clear(10);
    // frame start during ACCUM is dropped
    send_frame(3, 1);
    wait_level(50);
    d0 = drop_cnt;
    send_frame(5, 0);
    chk("frame_drop_pulse", drop_cnt - d0, 1);
    wait_burst();
    ack_clear(10);
    // all gray 0: no residue from previous frames
    send_frame(2, 1);
    chk("model_pin_zero", cdf_exp[0], 8);
    wait_burst();
    chk("zero_last_entry", pixel_cnt_num, 8);
    ack_clear(3);
    // reset in the middle of ACCUM
    send_frame(3, 1);
    wait_level(100);
    #1 rst_n = 0;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_timing();
    for (int f = 0; f < 5; f++) begin
      send_frame(f[0] ? 4 : 3, 1);
      wait_burst();
      chk("frame_total", pixel_cnt_num, N);
      ack_clear($urandom_range(1, 20));
    end
    chk("drop_total", drop_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hist_stat_accum.md
# hist_stat_accum

Upstream stage of the histogram-equalisation path. Counts how many pixels of each 8-bit gray level occur in one active frame, then streams the cumulative histogram (CDF) for levels 0..255 to the equalisation mapper. It waits for the mapper to acknowledge the full table, then clears its counters for the next frame.

## Interface
- H_DISP, 11'd800, active pixels per line
- V_DISP, 11'd600, active lines per frame
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset; asynchronous, active-low
- pre_img_vsync  input  1  frame sync; a falling edge marks frame start
- pre_img_hsync  input  1  line sync; not used for counting
- pre_img_valid  input  1  pixel qualifier
- pre_img_gray  input  8  pixel gray level
- pixel_level  output  8  gray level of the current CDF entry
- pixel_cnt_num  output  21  cumulative count for levels 0..pixel_level
- pixel_level_vld  output  1  CDF entry strobe
- pixel_write_ok  input  1  one-cycle acknowledge from the mapper after it has taken level 255
- hist_busy  output  1  high in every state except IDLE and STAT
- frame_drop  output  1  one-cycle pulse when a frame start arrives in ACCUM, WAIT_OK or CLEAR

## Operation
- Storage: 256 x 21-bit histogram array, level-indexed. Use a register file or dual-port RAM with 1-cycle read latency.
- Frame-start detect: register pre_img_vsync twice (vs_r, vs_r1). vsync_neg = !vs_r & vs_r1.
- States: CLEAR, IDLE, STAT, ACCUM, WAIT_OK.
- CLEAR
  - Writes 0 to addresses 0..255, one per cycle (256 cycles).
  - Then goes to IDLE.
  - Entered directly from reset and after WAIT_OK.
- IDLE
  - On vsync_neg: go to STAT, zero the frame pixel counter pix_cnt.
- STAT
  - Each pixel with pre_img_valid: hist[gray] += 1, pix_cnt += 1.
  - Read-modify-write pipeline is 2 stages.
  - If stage-2 write address equals the stage-1 read address, forward the stage-2 write data. Back-to-back identical levels must count exactly.
  - When pix_cnt reaches H_DISP*V_DISP (last pixel accepted), wait for the pipeline to drain (2 cycles), then go to ACCUM.
  - Valid pixels after that count are ignored.
- ACCUM
  - Reads levels 0..255 in order, keeping a running sum acc.
  - Emits pixel_level=k, pixel_cnt_num=acc_k with pixel_level_vld=1 for 256 consecutive cycles, no gaps.
  - Then goes to WAIT_OK.
- WAIT_OK
  - Holds until pixel_write_ok=1, then goes to CLEAR. No timeout.
- vsync_neg while in ACCUM, WAIT_OK or CLEAR: that frame is not counted; frame_drop pulses for 1 cycle.
- vsync_neg while in STAT: restarts counting. Counts already accumulated remain.
- Arithmetic and widths:
  - hist entries and acc are 21 bits. The maximum is 480000 < 2^21, so there is no overflow for default parameters.
  - No saturation logic.
  - The level-255 entry always equals H_DISP*V_DISP for a complete frame.

## Timing
- Reset values: pixel_level=0, pixel_cnt_num=0, pixel_level_vld=0, frame_drop=0, hist_busy=1. State is CLEAR and pix_cnt=0.
- Ready 256 cycles after reset release (hist_busy falls on cycle 257).
- Reset mid-operation (any state): outputs return to reset values immediately; the full 256-cycle CLEAR repeats.
- STAT latency: the last valid pixel lands in the array 2 cycles after acceptance. The first pixel_level_vld (level 0) is asserted no later than 4 cycles after the last pixel.
- ACCUM outputs are registered.
  - pixel_level_vld is high for exactly 256 cycles.
  - pixel_level increments by 1 per cycle, 0 to 255. It holds 255 after the burst; pixel_cnt_num holds its last value.
- pixel_write_ok is sampled only in WAIT_OK. It is ignored elsewhere, including during the ACCUM burst.
- hist_busy rises on the cycle the state enters ACCUM and falls on the cycle CLEAR exits to IDLE.
- Blanking requirement: end of frame to the next vsync_neg must be at least 256 + 2 + ack delay + 256 cycles, or the next frame is dropped.

## Test plan
- H_DISP=4, V_DISP=2, gray sequence 0,1,2,3,4,5,6,7 -> CDF entries: level k gives k+1 for k<8, and 8 for levels 8..255. 256 consecutive vld cycles.
- H_DISP=4, V_DISP=2, all pixels gray 200, back-to-back valid -> CDF 0 for levels 0..199, 8 for levels 200..255. This checks forwarding.
- Acknowledge pixel_write_ok 10 cycles after the level-255 entry -> CLEAR starts the next cycle. After 256 cycles hist_busy=0. The next frame of all gray 0 gives CDF 8 at level 0, with no residue from the previous frame.
- vsync falling edge during ACCUM -> frame_drop=1 for one cycle. The ACCUM burst completes unaltered; that frame's pixels are not counted.
- Assert rst_n=0 at level 100 of ACCUM -> pixel_level_vld=0 and pixel_cnt_num=0 immediately. After release, hist_busy stays 1 for 256 cycles. The following frame yields a correct CDF.
- Default 800x600 frame of random gray -> level-255 entry = 480000, CDF monotonic non-decreasing, and per-level differences match a reference histogram.
